mux_share_arbiter: RTL and testbench



---
 rtl/mux_share_arbiter_if.sv | 25 ++
 rtl/mux_share_arbiter.sv | 99 +++++++++
 tb/tb_mux_share_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mux_share_arbiter_if.sv
// Handshake and datapath bundle between the requesters and the shared-mux arbiter.
// master = requester side, slave = arbiter side.
interface mux_share_arbiter_if #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 8
);
   logic [1:0]        req;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic [1:0]        gnt;
   logic              sel;
   logic [DATA_W-1:0] dout;
   logic              valid;
   logic [CNT_W-1:0]  hold_cnt;

   modport master (
      output req, data0, data1,
      input  gnt, sel, dout, valid, hold_cnt
   );

   modport slave (
      input  req, data0, data1,
      output gnt, sel, dout, valid, hold_cnt
   );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux, with a MAX_HOLD
// timeslot limit under contention and registered grant/select/data outputs.
module mux_share_arbiter #(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 8
) (
   input logic              Clock,
   input logic              Reset,
   mux_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t            state, state_nxt;
   logic              last, last_nxt;
   logic              sel_r, sel_nxt;
   logic [DATA_W-1:0] dout_r, dout_nxt;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt;
   logic              mine, other;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         last  <= 1'b1;
         sel_r <= 1'b0;
         dout_r <= '0;
         cnt_r <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         sel_r <= sel_nxt;
         dout_r <= dout_nxt;
         cnt_r <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      sel_nxt   = sel_r;
      cnt_nxt   = '0;
      mine      = 1'b0;
      other     = 1'b0;

      case (state)
         IDLE: begin
            case (bus.req)
               2'b01:   state_nxt = G0;
               2'b10:   state_nxt = G1;
               2'b11:   state_nxt = last ? G0 : G1;
               default: state_nxt = IDLE;
            endcase
         end
         G0, G1: begin
            mine  = (state == G0) ? bus.req[0] : bus.req[1];
            other = (state == G0) ? bus.req[1] : bus.req[0];
            if (!mine)
               state_nxt = other ? ((state == G0) ? G1 : G0) : IDLE;
            else if (other && cnt_r == HOLD_LAST)
               state_nxt = (state == G0) ? G1 : G0;
            else
               state_nxt = state;
         end
         default: state_nxt = IDLE;
      endcase

      // Counter only advances while the same grant persists; any entry clears it.
      if (state_nxt == state && state != IDLE)
         cnt_nxt = (cnt_r == '1) ? cnt_r : cnt_r + CNT_W'(1);

      if (state_nxt == G0) begin
         last_nxt = 1'b0;
         sel_nxt  = 1'b0;
      end else if (state_nxt == G1) begin
         last_nxt = 1'b1;
         sel_nxt  = 1'b1;
      end

      // NOT/AND/OR select path; in IDLE the last mux output is held.
      if (state_nxt == IDLE)
         dout_nxt = dout_r;
      else
         dout_nxt = (bus.data0 & {DATA_W{~sel_nxt}}) | (bus.data1 & {DATA_W{sel_nxt}});
   end

   assign bus.gnt      = {state == G1, state == G0};
   assign bus.valid    = (state != IDLE);
   assign bus.sel      = sel_r;
   assign bus.dout     = dout_r;
   assign bus.hold_cnt = cnt_r;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural owner/count model.
module tb_mux_share_arbiter;
   localparam int DW = 4;
   localparam int MH = 4;
   localparam int CW = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;

   mux_share_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

   mux_share_arbiter #(.DATA_W(DW), .MAX_HOLD(MH), .CNT_W(CW)) dut (
      .Clock(clk),
      .Reset(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: owner is -1 when idle, else the index of the granted requester.
   int owner = -1;
   int cnt = 0;
   int last_m = 1;
   int sel_m = 0;
   int dout_m = 0;
   int nxt;
   int mine_m, other_m;
   bit armed = 0;

   always @(posedge clk) begin
      if (rst) begin
         owner = -1; cnt = 0; last_m = 1; sel_m = 0; dout_m = 0; armed = 1;
      end else begin
         if (owner < 0) begin
            if (bus.req == 2'b11) nxt = 1 - last_m;
            else if (bus.req[0]) nxt = 0;
            else if (bus.req[1]) nxt = 1;
            else nxt = -1;
         end else begin
            mine_m = bus.req[owner];
            other_m = bus.req[1 - owner];
            if (mine_m == 0) nxt = other_m ? 1 - owner : -1;
            else if (other_m == 1 && cnt == MH - 1) nxt = 1 - owner;
            else nxt = owner;
         end
         if (nxt >= 0 && nxt == owner) cnt = (cnt == CNT_MAX) ? cnt : cnt + 1;
         else cnt = 0;
         if (nxt >= 0) begin
            last_m = nxt;
            sel_m = nxt;
            dout_m = (nxt == 1) ? int'(bus.data1) : int'(bus.data0);
         end
         owner = nxt;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("m_gnt", 32'(bus.gnt), (owner < 0) ? 32'd0 : 32'(1 << owner));
         check("m_valid", 32'(bus.valid), (owner < 0) ? 32'd0 : 32'd1);
         check("m_sel", 32'(bus.sel), 32'(sel_m));
         check("m_dout", 32'(bus.dout), 32'(dout_m));
         check("m_hold", 32'(bus.hold_cnt), 32'(cnt));
      end
   end

   task automatic cyc(input logic [1:0] r, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      bus.req = r;
      bus.data0 = d0;
      bus.data1 = d1;
      @(negedge clk);
   endtask

   logic [1:0] gpat;

   initial begin
      bus.req = 2'b11;
      bus.data0 = '0;
      bus.data1 = '0;
      rst = 1'b1;
      // Reset held two cycles with contention pending
      repeat (2) begin
         cyc(2'b11, 4'h3, 4'hC);
         check("rst_gnt", 32'(bus.gnt), 32'd0);
         check("rst_sel", 32'(bus.sel), 32'd0);
         check("rst_dout", 32'(bus.dout), 32'd0);
         check("rst_valid", 32'(bus.valid), 32'd0);
         check("rst_hold", 32'(bus.hold_cnt), 32'd0);
      end
      rst = 1'b0;
      cyc(2'b11, 4'h3, 4'hC);
      check("first_gnt", 32'(bus.gnt), 32'h1);
      check("first_dout", 32'(bus.dout), 32'h3);

      // Single requester, no forced switch
      cyc(2'b00, 4'h0, 4'hA);
      check("idle_gnt", 32'(bus.gnt), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc(2'b10, 4'h0, 4'hA);
         check("single_gnt", 32'(bus.gnt), 32'h2);
         check("single_hold", 32'(bus.hold_cnt), 32'(i));
      end
      cyc(2'b00, 4'h0, 4'h5);
      check("drop_gnt", 32'(bus.gnt), 32'd0);
      check("drop_sel", 32'(bus.sel), 32'd1);
      check("drop_dout", 32'(bus.dout), 32'hA);

      // Contention rotation: 01x4, 10x4, 01x4
      for (int i = 0; i < 12; i++) begin
         cyc(2'b11, 4'h5, 4'hA);
         gpat = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
         check("rot_gnt", 32'(bus.gnt), 32'(gpat));
         check("rot_hold", 32'(bus.hold_cnt), 32'(i % 4));
         check("rot_dout", 32'(bus.dout), (gpat == 2'b01) ? 32'h5 : 32'hA);
      end

      // Early release from G0 at hold_cnt=1
      cyc(2'b00, 4'h5, 4'hA);
      cyc(2'b01, 4'h5, 4'hA);
      cyc(2'b01, 4'h5, 4'hA);
      check("early_hold1", 32'(bus.hold_cnt), 32'd1);
      cyc(2'b10, 4'h5, 4'hA);
      check("early_gnt", 32'(bus.gnt), 32'h2);
      check("early_hold", 32'(bus.hold_cnt), 32'd0);

      // Tie breaking from IDLE after G1, then after G0
      repeat (3) cyc(2'b00, 4'h5, 4'hA);
      cyc(2'b11, 4'h5, 4'hA);
      check("tie_after_g1", 32'(bus.gnt), 32'h1);
      repeat (3) cyc(2'b00, 4'h5, 4'hA);
      cyc(2'b11, 4'h5, 4'hA);
      check("tie_after_g0", 32'(bus.gnt), 32'h2);

      // Reset mid-grant in G1 at hold_cnt=2
      cyc(2'b11, 4'h5, 4'hA);
      cyc(2'b11, 4'h5, 4'hA);
      check("mid_hold2", 32'(bus.hold_cnt), 32'd2);
      rst = 1'b1;
      cyc(2'b11, 4'h5, 4'hA);
      check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
      check("mid_rst_sel", 32'(bus.sel), 32'd0);
      check("mid_rst_dout", 32'(bus.dout), 32'd0);
      rst = 1'b0;
      cyc(2'b11, 4'h5, 4'hA);
      check("post_rst_gnt", 32'(bus.gnt), 32'h1);

      // Saturation of hold_cnt with no contention
      repeat (300) cyc(2'b01, 4'h6, 4'h9);
      check("sat_hold", 32'(bus.hold_cnt), 32'(CNT_MAX));
      check("sat_gnt", 32'(bus.gnt), 32'h1);

      // Randomized run with sticky request patterns and occasional reset
      bus.req = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 2'($urandom_range(0, 3));
         bus.data0 = DW'($urandom);
         bus.data1 = DW'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
